// File: rtl/btb_predict_ctrl.sv
// BTB client controller: lookup at fetch, in-flight prediction queue,
// resolve at EX with flush/redirect, BTB training writes and statistics.
//
// Ports:
//   CLK, nRST          clock, async active-low reset
//   fetch_*            fetch request; pred_npc/fetch_hold back to fetch
//   btb_pc/target/taken BTB read port
//   ex_*, ext_flush    EX resolution and external flush
//   flush/redirect_pc  registered mispredict flush and correct next PC
//   btb_wen/..._w      registered BTB write port
//   br_cnt/mp_cnt/q_err statistics and sticky queue underflow flag
module btb_predict_ctrl #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              fetch_valid,
    input  logic              fetch_stall,
    input  logic [WORD_W-1:0] fetch_pc,
    output logic [WORD_W-1:0] pred_npc,
    output logic              fetch_hold,
    output logic [WORD_W-1:0] btb_pc,
    input  logic [WORD_W-1:0] btb_target,
    input  logic              btb_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_taken,
    input  logic [WORD_W-1:0] ex_target,
    input  logic              ext_flush,
    output logic              flush,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              btb_wen,
    output logic [WORD_W-1:0] btb_pc_w,
    output logic [WORD_W-1:0] btb_target_w,
    output logic              btb_taken_w,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mp_cnt,
    output logic              q_err
);

    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] pc_mem  [DEPTH];
    logic [WORD_W-1:0] tgt_mem [DEPTH];
    logic              tk_mem  [DEPTH];

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic              flush_q, flush_d;
    logic [WORD_W-1:0] redir_q, redir_d;
    logic              wen_q, wen_d;
    logic [WORD_W-1:0] pcw_q, pcw_d;
    logic [WORD_W-1:0] tgtw_q, tgtw_d;
    logic              tkw_q, tkw_d;
    logic [CNT_W-1:0]  br_q, br_d;
    logic [CNT_W-1:0]  mp_q, mp_d;
    logic              qerr_q, qerr_d;

    logic              empty, full, pop, push, p;
    logic              mp, train, clear;
    logic [WORD_W-1:0] h_pc, h_tgt, h_seq, pn, an;
    logic              h_tk;

    // Lookup
    assign btb_pc   = fetch_pc;
    assign p        = fetch_valid & btb_taken;
    assign pred_npc = p ? btb_target : fetch_pc + WORD_W'(4);

    // Queue control
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == (PW+1)'(DEPTH));
    assign pop        = ex_valid & ~empty;
    assign push       = fetch_valid & ~fetch_stall & (~full | pop);
    assign fetch_hold = full & ~pop;

    // Resolve against head entry
    assign h_pc  = pc_mem[rd_q];
    assign h_tgt = tgt_mem[rd_q];
    assign h_tk  = tk_mem[rd_q];
    assign h_seq = h_pc + WORD_W'(4);
    assign pn    = h_tk ? h_tgt : h_seq;
    assign an    = (ex_branch & ex_taken) ? ex_target : h_seq;
    assign mp    = pop & (pn != an);
    assign train = pop & (ex_branch | h_tk);
    // Either flush source empties the queue and drops any same-cycle push
    assign clear = mp | ext_flush;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        flush_d = mp;
        redir_d = redir_q;
        wen_d   = train;
        pcw_d   = pcw_q;
        tgtw_d  = tgtw_q;
        tkw_d   = tkw_q;
        br_d    = br_q;
        mp_d    = mp_q;
        qerr_d  = qerr_q | (ex_valid & empty);

        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            unique case (1'b1)
                push & ~pop: cnt_d = cnt_q + (PW+1)'(1);
                pop & ~push: cnt_d = cnt_q - (PW+1)'(1);
                default:     cnt_d = cnt_q;
            endcase
        end

        if (mp) redir_d = an;

        if (train) begin
            pcw_d  = h_pc;
            tkw_d  = ex_branch & ex_taken;
            tgtw_d = ex_branch ? ex_target : h_tgt;
        end

        if (pop & ex_branch & ~(&br_q)) br_d = br_q + CNT_W'(1);
        if (mp & ~(&mp_q))              mp_d = mp_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            redir_q <= '0;
            wen_q   <= 1'b0;
            pcw_q   <= '0;
            tgtw_q  <= '0;
            tkw_q   <= 1'b0;
            br_q    <= '0;
            mp_q    <= '0;
            qerr_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            wen_q   <= wen_d;
            pcw_q   <= pcw_d;
            tgtw_q  <= tgtw_d;
            tkw_q   <= tkw_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
            qerr_q  <= qerr_d;
        end
    end

    // Entry storage; validity is tracked by the pointers alone
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_q]  <= fetch_pc;
            tgt_mem[wr_q] <= btb_target;
            tk_mem[wr_q]  <= p;
        end
    end

    assign flush        = flush_q;
    assign redirect_pc  = redir_q;
    assign btb_wen      = wen_q;
    assign btb_pc_w     = pcw_q;
    assign btb_target_w = tgtw_q;
    assign btb_taken_w  = tkw_q;
    assign br_cnt       = br_q;
    assign mp_cnt       = mp_q;
    assign q_err        = qerr_q;

endmodule

// File: doc/btb_predict_ctrl.md
Name: btb_predict_ctrl

Overview:
Client-side controller for the branch target buffer: drives the BTB read port at fetch, forms the predicted next PC, and carries each prediction through the pipeline in a small in-flight queue. At EX resolution it compares the prediction with the actual outcome, raises flush/redirect on mispredict, and issues the registered BTB write (WEN, pc_w, target_w, taken_w) that trains the BTB. Sits between the fetch stage, the EX branch-resolve logic and the BTB.

Parameters:
WORD_W, 32, PC/target width
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)
CNT_W, 16, statistics counter width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  async active-low reset
fetch_valid  in  1  instruction fetched this cycle
fetch_stall  in  1  fetch stage held; no push
fetch_pc  in  WORD_W  PC of fetched instruction
pred_npc  out  WORD_W  predicted next PC (comb)
fetch_hold  out  1  queue full, fetch must stall (comb)
btb_pc  out  WORD_W  BTB read address (= fetch_pc)
btb_target  in  WORD_W  BTB read target
btb_taken  in  1  BTB read prediction
ex_valid  in  1  instruction retiring from EX (pops head)
ex_branch  in  1  EX instruction is a branch
ex_taken  in  1  actual branch outcome
ex_target  in  WORD_W  actual branch target
ext_flush  in  1  jump/exception flush; clear queue, no training
flush  out  1  mispredict flush pulse (registered)
redirect_pc  out  WORD_W  correct next PC, valid with flush
btb_wen  out  1  BTB write enable (registered)
btb_pc_w  out  WORD_W  write PC
btb_target_w  out  WORD_W  write target
btb_taken_w  out  1  write outcome
br_cnt  out  CNT_W  resolved branches
mp_cnt  out  CNT_W  mispredicts
q_err  out  1  sticky: ex_valid with empty queue

Behaviour:
- Reset (nRST=0, async): queue empty, all registered outputs 0 (flush, redirect_pc, btb_wen, btb_pc_w, btb_target_w, btb_taken_w, br_cnt, mp_cnt, q_err).
- Lookup (comb): btb_pc=fetch_pc; p = fetch_valid & btb_taken; pred_npc = p ? btb_target : fetch_pc+4 (mod 2^WORD_W).
- Queue entry {pc, pred_taken, pred_target}, FIFO order. pop = ex_valid & !empty. push = fetch_valid & !fetch_stall & (!full | pop).
- fetch_hold = full & !pop. Push+pop in one cycle: count unchanged; pointers wrap modulo DEPTH.
- Resolve on pop, head H: pn = H.pred_taken ? H.pred_target : H.pc+4; an = (ex_branch & ex_taken) ? ex_target : H.pc+4; mp = (pn != an).
- Non-branch predicted taken counts as mispredict (an = H.pc+4).
- Next edge after mp: flush=1 for exactly one cycle, redirect_pc=an; queue cleared, same-cycle push discarded.
- Training, next edge after pop with (ex_branch | H.pred_taken): btb_wen=1 for one cycle, btb_pc_w=H.pc, btb_taken_w=ex_branch&ex_taken, btb_target_w=ex_branch ? ex_target : H.pred_target. Otherwise btb_wen=0; write fields hold last value.
- br_cnt += 1 on pop with ex_branch; mp_cnt += 1 on mp; both saturate at all-ones.
- ext_flush: queue cleared at edge; a pop in the same cycle still resolves, trains and counts; push discarded. No flush output unless mp.
- ex_valid & empty: no resolve, no write; q_err set, cleared only by reset.
- Reset mid-operation: pending flush/write dropped, counters cleared.

Test Plan:
- Reset, fetch_pc=0x100, btb_taken=0 -> pred_npc=0x104, all registered outputs 0, fetch_hold=0.
- Fetch 0x200 with btb_taken=1, btb_target=0x300; later pop with ex_branch=1, ex_taken=1, ex_target=0x300 -> no flush; next cycle btb_wen=1, pc_w=0x200, target_w=0x300, taken_w=1; br_cnt=1, mp_cnt=0.
- Fetch 0x40 predicted not-taken; resolve taken to 0x80 -> flush one cycle, redirect_pc=0x80, queue empty, mp_cnt=1, btb_wen with taken_w=0x1 target_w=0x80.
- Non-branch at 0x10 predicted taken to 0x90 -> flush, redirect_pc=0x14, btb_wen=1 taken_w=0 target_w=0x90.
- Push DEPTH=4 without pop -> fetch_hold=1, 5th fetch not pushed; then simultaneous pop+push -> hold drops, count stays 4, FIFO order preserved across wrap.
- ex_valid on empty queue -> q_err=1 sticky, btb_wen=0; ext_flush with 3 entries -> queue empty, flush=0.
